delay_line_var: RTL and testbench

DELAY_LINE_VAR -- requirements
Module: delay_line_var

---
 rtl/delay_line_pkg.sv | 13 +
 rtl/delay_line_var_if.sv | 27 ++
 rtl/delay_tap_mux.sv | 36 +++
 rtl/delay_line_var.sv | 77 +++++++
 tb/tb_delay_line_var.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/delay_line_pkg.sv
// Shared definitions for the variable delay line: FSM states and defaults.
package delay_line_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_PRIMED  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_line_var_if.sv
// Stream/control bundle of the variable delay line; clk and sync_reset stay outside.
interface delay_line_var_if
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();
  localparam int DW = $clog2(DEPTH + 1);

  logic             enable;
  logic             flush;
  logic [WIDTH-1:0] data_in;
  logic [DW-1:0]    delay_sel;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic [DW-1:0]    delay_eff;

  modport master (
    output enable, flush, data_in, delay_sel,
    input  data_out, valid, delay_eff
  );

  modport slave (
    input  enable, flush, data_in, delay_sel,
    output data_out, valid, delay_eff
  );
endinterface

// File: rtl/delay_tap_mux.sv
// Clamps the requested delay into 1..DEPTH and picks the matching stage.
module delay_tap_mux
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] stages,
  input  logic [DW-1:0]               delay_sel,
  output logic [WIDTH-1:0]            tap,
  output logic [DW-1:0]               delay_eff
);

  logic [DW-1:0] w_eff;

  // Zero means "shortest", anything past the last stage means "longest".
  always_comb begin
    w_eff = delay_sel;
    if (delay_sel == '0)
      w_eff = DW'(1);
    else if (delay_sel > DW'(DEPTH))
      w_eff = DW'(DEPTH);
  end

  // One-hot compare per stage avoids indexing with an oversized select.
  always_comb begin
    tap = '0;
    for (int k = 0; k < DEPTH; k++)
      if (w_eff == DW'(k + 1))
        tap = stages[k];
  end

  assign delay_eff = w_eff;

endmodule

// File: rtl/delay_line_var.sv
// Variable-length delay line stepped by enable, with fill tracking so that
// valid only marks samples that really traversed the selected delay.
module delay_line_var
  import delay_line_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int GATE_OUT = 1
) (
  input logic             clk,
  input logic             sync_reset,
  delay_line_var_if.slave bus
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [DW-1:0]               r_fill;
  logic [DW-1:0]               r_delay;
  state_t                      r_state;

  logic [WIDTH-1:0] w_tap;
  logic [DW-1:0]    w_delay_eff;
  logic [DW-1:0]    w_fill_inc;
  logic             w_gate;

  delay_tap_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tap (
    .stages    (r_stage),
    .delay_sel (bus.delay_sel),
    .tap       (w_tap),
    .delay_eff (w_delay_eff)
  );

  assign w_fill_inc = (r_fill == DW'(DEPTH)) ? r_fill : r_fill + DW'(1);

  // Shift register, fill counter and fill-state FSM; reset beats flush beats
  // delay change beats a plain enabled step.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_stage <= '0;
      r_fill  <= '0;
      r_state <= ST_EMPTY;
      r_delay <= w_delay_eff;
    end else begin
      r_delay <= w_delay_eff;
      if (bus.flush) begin
        r_stage <= '0;
        r_fill  <= '0;
        r_state <= ST_EMPTY;
      end else begin
        if (bus.enable) begin
          r_stage[0] <= bus.data_in;
          for (int k = 1; k < DEPTH; k++)
            r_stage[k] <= r_stage[k-1];
        end
        if (w_delay_eff != r_delay) begin
          // Contents stay, but the new tap is not yet trusted.
          r_fill  <= '0;
          r_state <= (r_state == ST_EMPTY && !bus.enable) ? ST_EMPTY : ST_FILLING;
        end else if (bus.enable) begin
          r_fill  <= w_fill_inc;
          r_state <= (w_fill_inc >= w_delay_eff) ? ST_PRIMED : ST_FILLING;
        end
      end
    end
  end

  assign w_gate = (GATE_OUT != 0) ? bus.enable : 1'b1;

  assign bus.data_out  = sync_reset ? '0 : (w_tap & {WIDTH{w_gate}});
  assign bus.valid     = !sync_reset && (r_state == ST_PRIMED) && w_gate;
  assign bus.delay_eff = w_delay_eff;

endmodule

// File: tb/tb_delay_line_var.sv
// Bench for delay_line_var: directed scenarios plus a random soak, all
// checked against a sample-history reference model.
module tb_delay_line_var;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int DW = $clog2(D + 1);

  logic clk;
  logic sync_reset;

  delay_line_var_if #(.WIDTH(W), .DEPTH(D)) bus ();

  delay_line_var #(
    .WIDTH    (W),
    .DEPTH    (D),
    .GATE_OUT (1)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of captured samples (index 0 = newest),
  // enabled steps since the delay was last established, and that delay.
  logic [W-1:0] m_hist [$];
  int           m_cnt  = 0;
  int           m_reff = 1;

  logic [W-1:0]  s_data;
  logic          s_valid;
  logic [DW-1:0] s_eff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampf(input int s);
    if (s == 0) return 1;
    if (s > D) return D;
    return s;
  endfunction

  task automatic m_clear();
    m_hist.delete();
    for (int k = 0; k < D; k++) m_hist.push_back('0);
    m_cnt = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int           eff;
    int           neff;
    logic [W-1:0] eo;
    logic         ev;
    @(negedge clk);
    s_data  = bus.data_out;
    s_valid = bus.valid;
    s_eff   = bus.delay_eff;
    eff = clampf(int'(bus.delay_sel));
    eo  = (sync_reset || !bus.enable) ? '0 : m_hist[eff-1];
    ev  = !sync_reset && bus.enable && (m_cnt > 0) && (m_cnt >= m_reff);
    chk("delay_eff", 32'(s_eff), 32'(eff));
    chk("data_out", 32'(s_data), 32'(eo));
    chk("valid", 32'(s_valid), 32'(ev));
    @(posedge clk);
    neff = clampf(int'(bus.delay_sel));
    if (sync_reset) begin
      m_clear();
    end else if (bus.flush) begin
      m_clear();
    end else begin
      if (bus.enable) begin
        m_hist.push_front(bus.data_in);
        void'(m_hist.pop_back());
      end
      if (neff != m_reff) m_cnt = 0;
      else if (bus.enable && m_cnt < D) m_cnt++;
    end
    m_reff = neff;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    m_clear();
    // Reset with flush, enable and a delay change all active.
    sync_reset    = 1'b1;
    bus.flush     = 1'b1;
    bus.enable    = 1'b1;
    bus.data_in   = 8'h5A;
    bus.delay_sel = DW'(20);
    cycle();
    chk("rst_eff_clamp_hi", 32'(s_eff), 32'(D));
    chk("rst_valid", 32'(s_valid), 0);
    bus.delay_sel = DW'(4);
    cycle();
    chk("rst_data", 32'(s_data), 0);
    sync_reset = 1'b0;
    bus.flush  = 1'b0;
    bus.enable = 1'b0;
    cycle();
    chk("post_rst_data", 32'(s_data), 0);
    chk("post_rst_valid", 32'(s_valid), 0);

    // Ramp 1,2,3.. with delay 4: first sample and valid on enabled cycle 5.
    for (int i = 1; i <= 8; i++) begin
      bus.enable  = 1'b1;
      bus.data_in = W'(i);
      cycle();
      if (i == 4) chk("ramp_valid_c4", 32'(s_valid), 0);
      if (i == 5) begin
        chk("ramp_data_c5", 32'(s_data), 1);
        chk("ramp_valid_c5", 32'(s_valid), 1);
      end
      if (i == 6) chk("ramp_data_c6", 32'(s_data), 2);
    end

    // Delay change 4 -> 8 while primed; the ramp keeps going.
    bus.delay_sel = DW'(8);
    bus.data_in   = 8'd9;
    cycle();
    for (int j = 1; j <= 9; j++) begin
      bus.data_in = W'(9 + j);
      cycle();
      if (j < 9) chk("chg_valid_low", 32'(s_valid), 0);
      else begin
        chk("chg_valid_rise", 32'(s_valid), 1);
        chk("chg_data", 32'(s_data), 10);
      end
    end

    // Clamp corners.
    bus.enable    = 1'b0;
    bus.delay_sel = DW'(0);
    cycle();
    chk("clamp_zero", 32'(s_eff), 1);
    bus.delay_sel = DW'(20);
    cycle();
    chk("clamp_over", 32'(s_eff), 16);

    // Enable every third cycle, delay 2; gated output zero when idle.
    bus.delay_sel = DW'(2);
    for (int i = 0; i < 30; i++) begin
      bus.enable  = (i % 3 == 0);
      bus.data_in = W'($urandom);
      cycle();
      if (i % 3 != 0) chk("gate_zero", 32'(s_data), 0);
    end

    // Flush together with enable mid-stream at delay 1.
    bus.delay_sel = DW'(1);
    for (int i = 0; i < 4; i++) begin
      bus.enable  = 1'b1;
      bus.data_in = W'(8'h30 + i);
      cycle();
    end
    bus.flush   = 1'b1;
    bus.data_in = 8'hAA;
    cycle();
    bus.flush   = 1'b0;
    bus.data_in = 8'h11;
    cycle();
    chk("flush_data", 32'(s_data), 0);
    chk("flush_valid", 32'(s_valid), 0);
    cycle();
    chk("after_flush_data", 32'(s_data), 32'h11);

    // Random soak.
    c = 0;
    while (c < 1500) begin
      sync_reset  = ($urandom % 100 == 0);
      bus.flush   = ($urandom % 50 == 0);
      bus.enable  = $urandom % 2;
      bus.data_in = W'($urandom);
      if ($urandom % 30 == 0) bus.delay_sel = DW'($urandom_range(0, 31));
      cycle();
      c++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
